// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// The producer/consumer side uses the master modport, the adder uses slave.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop adds two
// WIDTH-bit unsigned operands LSB-first, one bit per clock. One operation is
// in flight at a time; the result is held until the consumer takes it.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 sum bits produced so far; the bit from the current
    // cycle joins them combinationally to form the complete word.
    logic [WIDTH-2:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic             bit_s;
    logic             carry_next;
    logic [WIDTH-1:0] assembled;

    // Full-adder cell on the current LSBs plus the sum word as it would look after this bit.
    // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
    always_comb begin
        bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        assembled  = {bit_s, s_sh};
    end

    // Control FSM and datapath registers: accept in IDLE, one bit per cycle in RUN, present result in HOLD.
    // NOTE: sequential state uses non-blocking '<='; every register, including the shift registers, is cleared by the async reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            s_sh        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= carry_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= assembled[WIDTH-1:1];
                    if (cnt == CNT_LAST) begin
                        // cnt is left at its last value so it never wraps.
                        sum_q       <= assembled;
                        carry_out_q <= carry_next;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2. Drivers push
// the expected {carry_out,sum} into a queue at each accept; per-instance
// monitors pop and compare at every output transfer.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] mexp8;
    logic [2:0] mexp2;

    serial_adder_if #(.WIDTH(8)) ifc8 ();
    serial_adder_if #(.WIDTH(2)) ifc2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (rst_n && ifc8.out_valid)
            check("dut8 in_ready low in HOLD", 32'(ifc8.in_ready), 32'd0);
        if (rst_n && ifc8.out_valid && ifc8.out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected result: got %0h expected none", {ifc8.carry_out, ifc8.sum});
            end else begin
                mexp8 = q8.pop_front();
                check("dut8 result", 32'({ifc8.carry_out, ifc8.sum}), 32'(mexp8));
            end
        end
    end

    // Scoreboard monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        if (rst_n && ifc2.out_valid)
            check("dut2 in_ready low in HOLD", 32'(ifc2.in_ready), 32'd0);
        if (rst_n && ifc2.out_valid && ifc2.out_ready) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2 unexpected result: got %0h expected none", {ifc2.carry_out, ifc2.sum});
            end else begin
                mexp2 = q2.pop_front();
                check("dut2 result", 32'({ifc2.carry_out, ifc2.sum}), 32'(mexp2));
            end
        end
    end

    // Present operands and wait for the accept edge; leaves in_valid high.
    // Returns just after the accept edge; acc is that edge's cycle number.
    task automatic accept8(input logic [7:0] av, input logic [7:0] bv, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        ifc8.in_valid = 1'b1;
        ifc8.a        = av;
        ifc8.b        = bv;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ifc8.in_ready) begin
                q8.push_back(9'(av) + 9'(bv));
                acc  = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) timeout_fail("dut8 accept");
    endtask

    task automatic accept2(input logic [1:0] av, input logic [1:0] bv, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        ifc2.in_valid = 1'b1;
        ifc2.a        = av;
        ifc2.b        = bv;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ifc2.in_ready) begin
                q2.push_back(3'(av) + 3'(bv));
                acc  = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) timeout_fail("dut2 accept");
    endtask

    task automatic drain8();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (q8.size() == 0 && !ifc8.out_valid) done = 1'b1;
        end
        if (!done) timeout_fail("dut8 drain");
        @(posedge clk);
        #1;
    endtask

    task automatic drain2();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (q2.size() == 0 && !ifc2.out_valid) done = 1'b1;
        end
        if (!done) timeout_fail("dut2 drain");
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bb_a [6] = '{8'h12, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'hC8};
    logic [7:0] bb_b [6] = '{8'h34, 8'hFF, 8'h80, 8'h00, 8'h01, 8'h64};
    logic [1:0] w2_a [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [1:0] w2_b [4] = '{2'd3, 2'd2, 2'd2, 2'd1};

    initial begin
        int  acc;
        int  prev;
        int  lat;
        bit  stim_done;

        rst_n          = 1'b0;
        ifc8.in_valid  = 1'b0;
        ifc8.a         = '0;
        ifc8.b         = '0;
        ifc8.out_ready = 1'b1;
        ifc2.in_valid  = 1'b0;
        ifc2.a         = '0;
        ifc2.b         = '0;
        ifc2.out_ready = 1'b1;

        // Reset state.
        #12;
        check("reset dut8 in_ready", 32'(ifc8.in_ready), 32'd1);
        check("reset dut8 out_valid", 32'(ifc8.out_valid), 32'd0);
        check("reset dut8 sum/carry", 32'({ifc8.carry_out, ifc8.sum}), 32'd0);
        check("reset dut2 in_ready", 32'(ifc2.in_ready), 32'd1);
        check("reset dut2 out_valid", 32'(ifc2.out_valid), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency measurement: 3C + 5A = 096.
        accept8(8'h3C, 8'h5A, acc);
        ifc8.in_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (ifc8.out_valid) lat = cyc - acc;
        end
        check("latency WIDTH=8", 32'(lat), 32'd8);
        check("3C+5A value", 32'({ifc8.carry_out, ifc8.sum}), 32'h096);
        @(posedge clk);
        #1;
        drain8();

        // Overflow cases.
        accept8(8'hFF, 8'h01, acc);
        ifc8.in_valid = 1'b0;
        accept8(8'hFF, 8'hFF, acc);
        ifc8.in_valid = 1'b0;
        drain8();

        // Backpressure: A5 + 6E = 113 held for 5 cycles; new operands ignored.
        ifc8.out_ready = 1'b0;
        accept8(8'hA5, 8'h6E, acc);
        ifc8.in_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (ifc8.out_valid) lat = n;
        end
        if (lat < 0) timeout_fail("backpressure out_valid");
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b1;
        ifc8.a        = 8'h11;
        ifc8.b        = 8'h22;
        repeat (5) begin
            @(negedge clk);
            check("hold out_valid", 32'(ifc8.out_valid), 32'd1);
            check("hold sum/carry", 32'({ifc8.carry_out, ifc8.sum}), 32'h113);
            check("hold in_ready", 32'(ifc8.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        ifc8.in_valid  = 1'b0;
        ifc8.out_ready = 1'b1;
        drain8();
        repeat (10) begin
            @(negedge clk);
            check("no capture during HOLD", 32'(ifc8.out_valid), 32'd0);
        end
        check("sum kept after handshake", 32'({ifc8.carry_out, ifc8.sum}), 32'h113);
        @(posedge clk);
        #1;

        // Asynchronous reset in the third RUN cycle: C3 + 4D aborted.
        accept8(8'hC3, 8'h4D, acc);
        ifc8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(ifc8.out_valid), 32'd0);
        check("abort sum/carry", 32'({ifc8.carry_out, ifc8.sum}), 32'd0);
        check("abort in_ready", 32'(ifc8.in_ready), 32'd1);
        q8.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept8(8'h0F, 8'hF1, acc);
        ifc8.in_valid = 1'b0;
        drain8();

        // Back-to-back with in_valid and out_ready tied high.
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            accept8(bb_a[i], bb_b[i], acc);
            if (i > 0) check("b2b spacing WIDTH=8", 32'(acc - prev), 32'd10);
            prev = acc;
        end
        ifc8.in_valid = 1'b0;
        drain8();

        // WIDTH=2 directed, back-to-back.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            accept2(w2_a[i], w2_b[i], acc);
            if (i > 0) check("b2b spacing WIDTH=2", 32'(acc - prev), 32'd4);
            prev = acc;
        end
        ifc2.in_valid = 1'b0;
        drain2();

        // Random operands with random output stalls, WIDTH=8.
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    accept8(8'($urandom), 8'($urandom), acc);
                    if ($urandom_range(0, 3) == 0) ifc8.in_valid = 1'b0;
                end
                ifc8.in_valid = 1'b0;
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    ifc8.out_ready = 1'($urandom_range(0, 1));
                end
                ifc8.out_ready = 1'b1;
            end
        join
        drain8();

        // Random operands with random output stalls, WIDTH=2.
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    accept2(2'($urandom), 2'($urandom), acc);
                    if ($urandom_range(0, 3) == 0) ifc2.in_valid = 1'b0;
                end
                ifc2.in_valid = 1'b0;
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    ifc2.out_ready = 1'($urandom_range(0, 1));
                end
                ifc2.out_ready = 1'b1;
            end
        join
        drain2();

        check("dut8 scoreboard empty", 32'(q8.size()), 32'd0);
        check("dut2 scoreboard empty", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
